// File: rtl/mem_dcache_access_pkg.sv
// Shared types for the MEM-stage Dcache initiator.
// State encoding, access width codes, alignment helper.
package mem_dcache_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_R = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } dc_state_e;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  // Natural alignment of an access; width none never passes.
  function automatic logic width_ok(
    input logic [1:0] w,
    input logic [1:0] off
  );
    case (w)
      W_BYTE:  width_ok = 1'b1;
      W_HALF:  width_ok = ~off[0];
      W_WORD:  width_ok = (off == 2'b00);
      default: width_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_dcache_access_lane.sv
// Byte-lane steering between the pipeline and the Dcache word bus.
// Store strobes/replication and load right-alignment.
module mem_lane_align
  import mem_dcache_access_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Strobe and lane replication by access width.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_width)
      W_BYTE: begin
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      W_HALF: begin
        o_wstrb = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      W_WORD: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

  assign o_rdata = i_rdata >> {i_off, 3'b000};

endmodule

// File: rtl/mem_dcache_access.sv
// MEM-stage initiator toward the Dcache.
// Issues loads/stores, aligns load data, raises stall to flow control.
module mem_dcache_access
  import mem_dcache_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid_i,
  input  logic        exmem_mtype_i,
  input  logic        exmem_store_i,
  input  logic [1:0]  exmem_width_i,
  input  logic [31:0] exmem_addr_i,
  input  logic [31:0] exmem_wdata_i,
  output logic        mem_dc_req_o,
  output logic        mem_dc_we_o,
  output logic [31:0] mem_dc_addr_o,
  output logic [31:0] mem_dc_wdata_o,
  output logic [3:0]  mem_dc_wstrb_o,
  input  logic        dc_ready_i,
  input  logic        dc_rvalid_i,
  input  logic [31:0] dc_rdata_i,
  output logic [31:0] mem_dcache_data_o,
  output logic        mem_dcache_data_valid_o,
  output logic        mem_stall_req_o,
  output logic        mem_misalign_o,
  output logic        mem_timeout_o,
  input  logic        fc_flush_mem_i,
  input  logic        fc_bk_mem_i
);

  localparam int unsigned CW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  dc_state_e   r_state;
  dc_state_e   w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_width;
  logic        r_store;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_data;
  logic        r_valid;

  logic        w_go;
  logic        w_flush;
  logic        w_mem;
  logic        w_ok;
  logic        w_idle;
  logic        w_accept;
  logic        w_misal;
  logic        w_active;
  logic        w_tmo;
  logic        w_drop;
  logic        w_req;
  logic        w_cap;
  logic        w_hold;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  // Back-and-keep outranks flush.
  assign w_go     = ~rst;
  assign w_flush  = fc_flush_mem_i & ~fc_bk_mem_i;
  assign w_mem    = exmem_valid_i & exmem_mtype_i
                  & ~fc_flush_mem_i & ~fc_bk_mem_i;
  assign w_ok     = width_ok(exmem_width_i, exmem_addr_i[1:0]);
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_go & w_idle & w_mem & w_ok;
  assign w_misal  = w_go & w_idle & w_mem & ~w_ok;
  assign w_active = (r_state == S_REQ) | (r_state == S_WAIT_R)
                  | (r_state == S_DRAIN);
  assign w_tmo    = w_go & w_active & (TIMEOUT != 0)
                  & (32'(r_cnt) == TIMEOUT - 1);
  assign w_drop   = (r_state == S_REQ) & w_flush & ~dc_ready_i;
  assign w_req    = w_go & (r_state == S_REQ) & ~w_tmo & ~w_drop;
  assign w_cap    = w_go & (r_state == S_WAIT_R) & dc_rvalid_i
                  & ~w_flush & ~w_tmo;
  assign w_hold   = r_valid & fc_bk_mem_i;

  mem_lane_align u_lane (
    .i_width (r_width),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (dc_rdata_i),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_rdata (w_ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; watchdog abort overrides everything.
  always_comb begin
    w_next = r_state;
    if (w_tmo) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hold)        w_next = S_HOLD;
          else if (w_accept) w_next = S_REQ;
        end
        S_REQ: begin
          if (w_drop)
            w_next = S_IDLE;
          else if (dc_ready_i)
            w_next = r_store ? S_IDLE
                   : (w_flush ? S_DRAIN : S_WAIT_R);
        end
        S_WAIT_R: begin
          if (w_flush)
            w_next = dc_rvalid_i ? S_IDLE : S_DRAIN;
          else if (dc_rvalid_i)
            w_next = fc_bk_mem_i ? S_HOLD : S_IDLE;
        end
        S_DRAIN: begin
          if (dc_rvalid_i) w_next = S_IDLE;
        end
        S_HOLD: begin
          if (!fc_bk_mem_i) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Capture the accepted instruction for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_width <= W_NONE;
      r_store <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= exmem_addr_i;
      r_wdata <= exmem_wdata_i;
      r_width <= exmem_width_i;
      r_store <= exmem_store_i;
    end
  end

  // Watchdog: restarts per access, runs while a request is outstanding.
  always_ff @(posedge clk) begin
    if (rst)           r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_active) r_cnt <= r_cnt + CW'(1);
  end

  // Load result: one-cycle valid, held only under back-and-keep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 32'h0;
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_data  <= w_ld_data;
      r_valid <= 1'b1;
    end else if (!w_hold) begin
      r_data  <= 32'h0;
      r_valid <= 1'b0;
    end
  end

  // Outputs; bus fields are zero whenever no request is driven.
  always_comb begin
    mem_dc_req_o            = w_req;
    mem_dc_we_o             = w_req & r_store;
    mem_dc_addr_o           = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
    mem_dc_wdata_o          = w_req ? w_wdata : 32'h0;
    mem_dc_wstrb_o          = w_req ? w_wstrb : 4'b0000;
    mem_dcache_data_o       = r_data;
    mem_dcache_data_valid_o = r_valid;
    mem_stall_req_o         = w_accept
                            | (w_go & w_active & ~w_tmo & ~w_drop);
    mem_misalign_o          = w_misal;
    mem_timeout_o           = w_tmo;
  end

endmodule
